// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler and its hash cores.
package sha_sched_pkg;

    localparam int MAX_ID_W = 8;

    typedef struct packed {
        logic [15:0]         msg_addr;
        logic [15:0]         out_addr;
        logic [MAX_ID_W-1:0] id;
    } job_t;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_START,
        CORE_BUSY,
        CORE_DONEPEND
    } core_state_t;

    // H0..H7, word 0 in the most significant position.
    localparam logic [255:0] SHA256_H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sha256_iv_word(input int unsigned idx);
        return SHA256_H_INIT[255 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/sha_job_scheduler_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held while the owner keeps requesting.
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 release_gnt,
    output logic [NUM_CORES-1:0] gnt
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IDX_W-1:0]     last_idx;
    logic [IDX_W-1:0]     idx_next;
    logic [NUM_CORES-1:0] gnt_next;
    logic                 found;
    logic                 port_free;

    assign port_free = (gnt == '0) || release_gnt;

    // Search begins one past the last granted core so every requester gets a turn.
    always_comb begin
        gnt_next = '0;
        idx_next = last_idx;
        found    = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!found && req[(int'(last_idx) + k) % NUM_CORES]) begin
                found    = 1'b1;
                idx_next = IDX_W'((int'(last_idx) + k) % NUM_CORES);
                gnt_next[(int'(last_idx) + k) % NUM_CORES] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= '0;
            last_idx <= IDX_W'(NUM_CORES - 1);
        end else if (port_free) begin
            gnt <= gnt_next;
            if (found) last_idx <= idx_next;
        end
    end

endmodule

// File: rtl/sha_job_scheduler.sv
// Job queue, per-core dispatch/completion state machines and shared memory-port
// mux sitting between the top-level memory and an array of SHA-256 hash cores.
module sha_job_scheduler
    import sha_sched_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [15:0]             job_msg_addr,
    input  logic [15:0]             job_out_addr,
    input  logic [ID_W-1:0]         job_id,
    output logic                    cmp_valid,
    input  logic                    cmp_ready,
    output logic [ID_W-1:0]         cmp_id,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES*16-1:0] core_msg_addr,
    output logic [NUM_CORES*16-1:0] core_out_addr,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_mem_req,
    output logic [NUM_CORES-1:0]    core_mem_gnt,
    input  logic [NUM_CORES-1:0]    core_mem_we,
    input  logic [NUM_CORES*16-1:0] core_mem_addr,
    input  logic [NUM_CORES*32-1:0] core_mem_wdata,
    output logic [31:0]             core_mem_rdata,
    output logic                    mem_clk,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    function automatic logic [NUM_CORES-1:0] lowest_one(input logic [NUM_CORES-1:0] v);
        return v & (~v + NUM_CORES'(1));
    endfunction

    job_t                 fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic                 fifo_empty, fifo_full, push, pop;
    job_t                 head;

    core_state_t          core_state    [NUM_CORES];
    core_state_t          core_state_nx [NUM_CORES];
    job_t                 core_job      [NUM_CORES];
    logic [NUM_CORES-1:0] idle_vec, pend_vec, disp_oh, cmp_sel;
    logic                 cmp_pop;
    logic [MAX_ID_W-1:0]  cmp_id_full;
    logic                 unused_id_bits;
    logic                 mem_release;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign job_ready  = !fifo_full;
    assign push       = job_valid && job_ready;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{msg_addr: job_msg_addr,
                                             out_addr: job_out_addr,
                                             id:       MAX_ID_W'(job_id)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_comb begin
        idle_vec   = '0;
        pend_vec   = '0;
        core_start = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idle_vec[i]   = (core_state[i] == CORE_IDLE);
            pend_vec[i]   = (core_state[i] == CORE_DONEPEND);
            core_start[i] = (core_state[i] == CORE_START);
        end
    end

    // Lowest-index idle core takes the head; lowest-index finished core reports first.
    assign disp_oh   = fifo_empty ? '0 : lowest_one(idle_vec);
    assign pop       = |disp_oh;
    assign cmp_sel   = lowest_one(pend_vec);
    assign cmp_valid = |pend_vec;
    assign cmp_pop   = cmp_valid && cmp_ready;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_state_nx[i] = core_state[i];
            case (core_state[i])
                CORE_IDLE:     if (disp_oh[i]) core_state_nx[i] = CORE_START;
                CORE_START:    core_state_nx[i] = CORE_BUSY;
                CORE_BUSY:     if (core_done[i]) core_state_nx[i] = CORE_DONEPEND;
                CORE_DONEPEND: if (cmp_pop && cmp_sel[i]) core_state_nx[i] = CORE_IDLE;
                default:       core_state_nx[i] = CORE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                core_state[i] <= CORE_IDLE;
                core_job[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                core_state[i] <= core_state_nx[i];
                if (disp_oh[i]) core_job[i] <= head;
            end
        end
    end

    always_comb begin
        core_msg_addr = '0;
        core_out_addr = '0;
        cmp_id_full   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_msg_addr[i*16 +: 16] = core_job[i].msg_addr;
            core_out_addr[i*16 +: 16] = core_job[i].out_addr;
            if (cmp_sel[i]) cmp_id_full = core_job[i].id;
        end
    end

    assign cmp_id         = cmp_id_full[ID_W-1:0];
    assign unused_id_bits = ^cmp_id_full;

    // Shared memory port: a core releases the port by dropping its request.
    assign mem_release = |(core_mem_gnt & ~core_mem_req);

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (core_mem_req),
        .release_gnt (mem_release),
        .gnt         (core_mem_gnt)
    );

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            mem_we         = mem_we | (core_mem_gnt[i] & core_mem_we[i]);
            mem_addr       = mem_addr | ({16{core_mem_gnt[i]}} & core_mem_addr[i*16 +: 16]);
            mem_write_data = mem_write_data | ({32{core_mem_gnt[i]}} & core_mem_wdata[i*32 +: 32]);
        end
    end

    assign core_mem_rdata = mem_read_data;
    assign mem_clk        = clk;

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Self-checking bench for sha_job_scheduler: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sha_job_scheduler;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            job_valid;
    logic            job_ready;
    logic [15:0]     job_msg_addr, job_out_addr;
    logic [IW-1:0]   job_id;
    logic            cmp_valid, cmp_ready;
    logic [IW-1:0]   cmp_id;
    logic [NC-1:0]   core_start;
    logic [NC*16-1:0] core_msg_addr, core_out_addr;
    logic [NC-1:0]   core_done, core_mem_req, core_mem_gnt, core_mem_we;
    logic [NC*16-1:0] core_mem_addr;
    logic [NC*32-1:0] core_mem_wdata;
    logic [31:0]     core_mem_rdata;
    logic            mem_clk, mem_we;
    logic [15:0]     mem_addr;
    logic [31:0]     mem_write_data, mem_read_data;

    int n_cmp  = 0;
    int n_fail = 0;

    sha_job_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .ID_W(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr), .job_id(job_id),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
        .core_start(core_start), .core_msg_addr(core_msg_addr), .core_out_addr(core_out_addr),
        .core_done(core_done), .core_mem_req(core_mem_req), .core_mem_gnt(core_mem_gnt),
        .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .core_mem_rdata(core_mem_rdata), .mem_clk(mem_clk), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending-job queue plus what each core is doing.
    typedef struct {
        logic [15:0]   m;
        logic [15:0]   o;
        logic [IW-1:0] id;
    } mjob_t;
    localparam int M_FREE = 0, M_STARTING = 1, M_RUNNING = 2, M_FINISHED = 3;
    mjob_t mq[$];
    mjob_t mjob[NC];
    int    mstat[NC];

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < NC; i++) mstat[i] = M_FREE;
    endtask

    task automatic model_step();
        int nst[NC];
        int disp;
        int rep;
        bit acc;
        disp = -1;
        rep  = -1;
        acc  = job_valid && (mq.size() < FD);
        for (int i = 0; i < NC; i++) begin
            nst[i] = mstat[i];
            if (rep < 0 && mstat[i] == M_FINISHED) rep = i;
            if (disp < 0 && mstat[i] == M_FREE && mq.size() > 0) disp = i;
        end
        for (int i = 0; i < NC; i++) begin
            if (mstat[i] == M_STARTING) nst[i] = M_RUNNING;
            else if (mstat[i] == M_RUNNING && core_done[i]) nst[i] = M_FINISHED;
            else if (mstat[i] == M_FINISHED && i == rep && cmp_ready) nst[i] = M_FREE;
        end
        if (disp >= 0) begin
            mjob[disp] = mq.pop_front();
            nst[disp]  = M_STARTING;
        end
        if (acc) mq.push_back('{job_msg_addr, job_out_addr, job_id});
        for (int i = 0; i < NC; i++) mstat[i] = nst[i];
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        job_valid = 0; job_msg_addr = 0; job_out_addr = 0; job_id = 0;
        cmp_ready = 0; core_done = 0; core_mem_req = 0; core_mem_we = 0;
        core_mem_addr = 0; core_mem_wdata = 0; mem_read_data = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic push_job(input logic [15:0] m, input logic [15:0] o, input logic [IW-1:0] id);
        job_valid = 1; job_msg_addr = m; job_out_addr = o; job_id = id;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        model_clear();
        @(posedge clk); #1;
        n_cmp++;
        if (core_start !== '0 || cmp_valid !== 1'b0 || core_mem_gnt !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: start=%b cmp_valid=%b gnt=%b required 0/0/0", core_start, cmp_valid, core_mem_gnt);
        end
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_write_data !== 32'h0 || cmp_id !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: we=%b addr=%h wdata=%h cmp_id=%h required all 0", mem_we, mem_addr, mem_write_data, cmp_id);
        end
        n_cmp++;
        if (core_msg_addr !== '0 || core_out_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_core_addr: msg=%h out=%h required 0", core_msg_addr, core_out_addr);
        end
        @(posedge clk); #1 reset_n = 1;
        #1;
        n_cmp++;
        if (job_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_job_ready: got %b required 1", job_ready);
        end
    endtask

    task automatic test_single_job();
        do_reset();
        push_job(16'h0000, 16'h0100, 4'd3);
        cycle();
        job_valid = 0;
        n_cmp++;
        if (core_start !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_start_early: got %b required 0000", core_start);
        end
        cycle();
        n_cmp++;
        if (core_start !== 4'b0001 || core_msg_addr[15:0] !== 16'h0000 || core_out_addr[15:0] !== 16'h0100) begin
            n_fail++;
            $display("FAIL single_start: start=%b msg=%h out=%h required 0001/0000/0100", core_start, core_msg_addr[15:0], core_out_addr[15:0]);
        end
        cycle();
        n_cmp++;
        if (core_start !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_start_pulse: got %b required 0000", core_start);
        end
        core_done = 4'b0001;
        cycle();
        core_done = 0;
        n_cmp++;
        if (cmp_valid !== 1'b1 || cmp_id !== 4'd3) begin
            n_fail++;
            $display("FAIL single_cmp: valid=%b id=%0d required 1/3", cmp_valid, cmp_id);
        end
        cmp_ready = 1;
        cycle();
        cmp_ready = 0;
        n_cmp++;
        if (cmp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cmp_pop: valid=%b required 0", cmp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int next_core;
        next_core = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 6) push_job(16'h1000 + 16'(c), 16'h2000 + 16'(c), IW'(c));
            else job_valid = 0;
            cycle();
            n_cmp++;
            if (job_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready c=%0d: got %b required 1", c, job_ready);
            end
            if (core_start !== 4'b0000) begin
                n_cmp++;
                if (next_core >= NC || core_start !== 4'(1 << next_core) ||
                    core_msg_addr[next_core*16 +: 16] !== 16'h1000 + 16'(next_core)) begin
                    n_fail++;
                    $display("FAIL b2b_start: start=%b required one-hot core %0d", core_start, next_core);
                end
                next_core++;
            end
        end
        job_valid = 0;
        n_cmp++;
        if (next_core !== 4) begin
            n_fail++;
            $display("FAIL b2b_start_count: got %0d required 4", next_core);
        end
    endtask

    task automatic test_fifo_full();
        int k;
        k = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            n_cmp++;
            if (job_ready !== (c < 8)) begin
                n_fail++;
                $display("FAIL full_ready c=%0d: got %b required %b", c, job_ready, (c < 8));
            end
            if (job_ready) begin
                push_job(16'h3000 + 16'(k), 16'h4000 + 16'(k), IW'(k));
                k++;
            end else begin
                job_valid = 1;
            end
            cycle();
        end
        job_valid = 0;
        n_cmp++;
        if (k !== 8) begin
            n_fail++;
            $display("FAIL full_accepted: got %0d required 8", k);
        end
        core_done = 4'b0001;
        cycle();
        core_done = 0;
        n_cmp++;
        if (cmp_valid !== 1'b1 || cmp_id !== 4'd0) begin
            n_fail++;
            $display("FAIL full_cmp: valid=%b id=%0d required 1/0", cmp_valid, cmp_id);
        end
        cmp_ready = 1;
        cycle();
        cmp_ready = 0;
        cycle();
        n_cmp++;
        if (core_start !== 4'b0001 || core_msg_addr[15:0] !== 16'h3004 || job_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_redispatch: start=%b msg=%h ready=%b required 0001/3004/1", core_start, core_msg_addr[15:0], job_ready);
        end
    endtask

    task automatic test_simul_done();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            push_job(16'h0a00 + 16'(c), 16'h0b00 + 16'(c), IW'(4 + c));
            cycle();
        end
        job_valid = 0;
        repeat (4) cycle();
        core_done = 4'b0110;
        cmp_ready = 1;
        cycle();
        core_done = 0;
        n_cmp++;
        if (cmp_valid !== 1'b1 || cmp_id !== 4'd5) begin
            n_fail++;
            $display("FAIL simul_first: valid=%b id=%0d required 1/5", cmp_valid, cmp_id);
        end
        cycle();
        n_cmp++;
        if (cmp_valid !== 1'b1 || cmp_id !== 4'd6) begin
            n_fail++;
            $display("FAIL simul_second: valid=%b id=%0d required 1/6", cmp_valid, cmp_id);
        end
        cycle();
        cmp_ready = 0;
        n_cmp++;
        if (cmp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drain: valid=%b required 0", cmp_valid);
        end
    endtask

    task automatic test_arbiter();
        int order[3];
        int exp_c;
        order = '{0, 1, 3};
        do_reset();
        for (int i = 0; i < NC; i++) begin
            core_mem_addr[i*16 +: 16]  = 16'($urandom);
            core_mem_wdata[i*32 +: 32] = $urandom;
        end
        core_mem_we = 4'b1011;
        #1;
        n_cmp++;
        if (core_mem_gnt !== '0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL arb_nogrant: gnt=%b we=%b addr=%h wdata=%h required zeros", core_mem_gnt, mem_we, mem_addr, mem_write_data);
        end
        core_mem_req = 4'b1011;
        cycle();
        for (int c = 0; c < 24; c++) begin
            exp_c = order[(c / 4) % 3];
            mem_read_data = $urandom;
            #1;
            n_cmp++;
            if (core_mem_gnt !== 4'(1 << exp_c) || mem_addr !== core_mem_addr[exp_c*16 +: 16] ||
                mem_write_data !== core_mem_wdata[exp_c*32 +: 32] || mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL arb_grant c=%0d: gnt=%b addr=%h required core %0d addr=%h", c, core_mem_gnt, mem_addr, exp_c, core_mem_addr[exp_c*16 +: 16]);
            end
            n_cmp++;
            if (core_mem_rdata !== mem_read_data) begin
                n_fail++;
                $display("FAIL arb_rdata c=%0d: got %h required %h", c, core_mem_rdata, mem_read_data);
            end
            core_mem_req = 4'b1011;
            if (c % 4 == 3) core_mem_req[exp_c] = 1'b0;
            cycle();
        end
        core_mem_req = 0;
        cycle();
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            push_job(16'h5000 + 16'(c), 16'h6000 + 16'(c), IW'(c));
            cycle();
        end
        job_valid = 0;
        core_done = 4'b0001;
        core_mem_req = 4'b0100;
        core_mem_we = 4'b0100;
        core_mem_addr[2*16 +: 16] = 16'hbeef;
        cycle();
        core_done = 0;
        n_cmp++;
        if (core_mem_gnt !== 4'b0100 || mem_we !== 1'b1 || mem_addr !== 16'hbeef || cmp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: gnt=%b we=%b addr=%h cmp_valid=%b required 0100/1/beef/1", core_mem_gnt, mem_we, mem_addr, cmp_valid);
        end
        reset_n = 0;
        #2;
        n_cmp++;
        if (core_mem_gnt !== '0 || mem_we !== 1'b0 || cmp_valid !== 1'b0 || core_start !== '0 || core_msg_addr !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: gnt=%b we=%b cmp_valid=%b start=%b msg=%h required zeros", core_mem_gnt, mem_we, cmp_valid, core_start, core_msg_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_inputs();
        model_clear();
        reset_n = 1;
        #1;
        n_cmp++;
        if (job_ready !== 1'b1 || cmp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: ready=%b cmp_valid=%b required 1/0", job_ready, cmp_valid);
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_cmp++;
            if (core_start !== '0) begin
                n_fail++;
                $display("FAIL midrst_fifo_empty c=%0d: start=%b required 0000", c, core_start);
            end
        end
        push_job(16'h7777, 16'h8888, 4'd9);
        cycle();
        job_valid = 0;
        cycle();
        n_cmp++;
        if (core_start !== 4'b0001 || core_msg_addr[15:0] !== 16'h7777) begin
            n_fail++;
            $display("FAIL midrst_next_job: start=%b msg=%h required 0001/7777", core_start, core_msg_addr[15:0]);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] exp_start;
        logic          exp_cv;
        logic [IW-1:0] exp_id;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            exp_start = '0;
            exp_cv    = 1'b0;
            exp_id    = '0;
            for (int i = NC - 1; i >= 0; i--) begin
                if (mstat[i] == M_STARTING) exp_start[i] = 1'b1;
                if (mstat[i] == M_FINISHED) begin
                    exp_cv = 1'b1;
                    exp_id = mjob[i].id;
                end
            end
            n_cmp++;
            if (job_ready !== (mq.size() < FD) || core_start !== exp_start) begin
                n_fail++;
                $display("FAIL rand_dispatch c=%0d: ready=%b start=%b required %b/%b", c, job_ready, core_start, (mq.size() < FD), exp_start);
            end
            n_cmp++;
            if (cmp_valid !== exp_cv || cmp_id !== exp_id) begin
                n_fail++;
                $display("FAIL rand_cmp c=%0d: valid=%b id=%0d required %b/%0d", c, cmp_valid, cmp_id, exp_cv, exp_id);
            end
            for (int i = 0; i < NC; i++) begin
                if (mstat[i] != M_FREE) begin
                    n_cmp++;
                    if (core_msg_addr[i*16 +: 16] !== mjob[i].m || core_out_addr[i*16 +: 16] !== mjob[i].o) begin
                        n_fail++;
                        $display("FAIL rand_core_addr c=%0d core=%0d: msg=%h out=%h required %h/%h", c, i, core_msg_addr[i*16 +: 16], core_out_addr[i*16 +: 16], mjob[i].m, mjob[i].o);
                    end
                end
            end
            job_valid    = ($urandom_range(0, 2) != 0);
            job_msg_addr = 16'($urandom);
            job_out_addr = 16'($urandom);
            job_id       = IW'($urandom_range(0, 15));
            for (int i = 0; i < NC; i++) core_done[i] = ($urandom_range(0, 3) == 0);
            cmp_ready    = ($urandom_range(0, 1) == 1);
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_single_job();
        test_back_to_back();
        test_fifo_full();
        test_simul_done();
        test_arbiter();
        test_reset_mid_job();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
